if_mem_ctrl: RTL and testbench

- Instruction-memory responder serving the fetch stage's request side.
- Accepts a 32-bit fetch address and performs four sequential reads on a byte-wide memory port (fixed 1-cycle read latency).
- Assembles the bytes little-endian into one instruction and returns it with its PC and a one-cycle valid pulse.
- Provides rdy_o so pc_reg and the fetch stage hold while a fetch is in flight; supports flush/redirect from branch resolution.

---
 rtl/if_mem_ctrl_pkg.sv | 16 +
 rtl/if_mem_ctrl_if.sv | 47 ++++
 rtl/if_mem_ctrl.sv | 119 +++++++++++
 tb/tb_if_mem_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_mem_ctrl_pkg.sv
// if_mem_ctrl_pkg: shared types and widths for the fetch-side memory responder.
// Holds FSM state encoding, instruction/byte widths and the zero word.
package if_mem_ctrl_pkg;

  localparam int INST_BYTES = 4;
  localparam int INST_W     = 32;
  localparam int BYTE_W     = 8;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    IF_MEM_IDLE = 1'b0,
    IF_MEM_BUSY = 1'b1
  } if_mem_state_e;

endpackage

// File: rtl/if_mem_ctrl_if.sv
// if_mem_ctrl_if: fetch request/response handshake plus byte-memory read port.
// slave = responder (if_mem_ctrl); master = fetch stage + memory side.
interface if_mem_ctrl_if
  import if_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 17
) ();

  logic                      req_i;
  logic [ADDR_WIDTH-1:0]     addr_i;
  logic                      flush_i;
  logic                      rdy_o;
  logic                      inst_valid_o;
  logic [INST_W-1:0]         inst_o;
  logic [ADDR_WIDTH-1:0]     inst_pc_o;
  logic                      mem_rd_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic [BYTE_W-1:0]         mem_data_i;

  modport slave (
    input  req_i,
    input  addr_i,
    input  flush_i,
    input  mem_data_i,
    output rdy_o,
    output inst_valid_o,
    output inst_o,
    output inst_pc_o,
    output mem_rd_o,
    output mem_addr_o
  );

  modport master (
    output req_i,
    output addr_i,
    output flush_i,
    output mem_data_i,
    input  rdy_o,
    input  inst_valid_o,
    input  inst_o,
    input  inst_pc_o,
    input  mem_rd_o,
    input  mem_addr_o
  );

endinterface

// File: rtl/if_mem_ctrl.sv
// if_mem_ctrl: reads 4 bytes per fetch from a 1-cycle byte memory, returns LE word.
// Ports: clk, rst (sync, active-high), bus (if_mem_ctrl_if.slave).
module if_mem_ctrl
  import if_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 17
) (
  input  logic            clk,
  input  logic            rst,
  if_mem_ctrl_if.slave    bus
);

  if_mem_state_e           r_state;
  if_mem_state_e           w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [2:0]              r_issue_cnt;
  logic [1:0]              r_recv_cnt;
  logic                    r_pend;
  logic [23:0]             r_asm;
  logic [INST_W-1:0]       r_inst;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic                    r_valid;

  logic                    w_accept;
  logic                    w_issue;
  logic                    w_flush;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IF_MEM_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      IF_MEM_IDLE: begin
        if (bus.req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = IF_MEM_BUSY;
        end
      end
      IF_MEM_BUSY: begin
        w_issue = (r_issue_cnt < 3'd4);
        if (bus.flush_i) begin
          // Redirect: a same-cycle request restarts
          // the fetch instead of dropping to IDLE.
          w_flush     = 1'b1;
          w_accept    = bus.req_i;
          w_state_nxt = bus.req_i ? IF_MEM_BUSY
                                  : IF_MEM_IDLE;
        end else if (r_pend && r_recv_cnt == 2'd3) begin
          w_state_nxt = IF_MEM_IDLE;
        end
      end
      default: w_state_nxt = IF_MEM_IDLE;
    endcase
  end

  assign w_mem_addr = r_base[MEM_ADDR_WIDTH-1:0]
                    + MEM_ADDR_WIDTH'(r_issue_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_pend      <= 1'b0;
      r_asm       <= '0;
      r_inst      <= ZERO_WORD;
      r_pc        <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_base      <= bus.addr_i;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_pend      <= 1'b0;
      end else if (w_flush) begin
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_pend      <= 1'b0;
      end else begin
        // r_pend marks a byte landing on
        // mem_data_i at the coming edge.
        r_pend <= w_issue;
        if (w_issue)
          r_issue_cnt <= r_issue_cnt + 3'd1;
        if (r_pend) begin
          r_recv_cnt <= r_recv_cnt + 2'd1;
          unique case (r_recv_cnt)
            2'd0: r_asm[7:0]   <= bus.mem_data_i;
            2'd1: r_asm[15:8]  <= bus.mem_data_i;
            2'd2: r_asm[23:16] <= bus.mem_data_i;
            2'd3: begin
              r_inst  <= {bus.mem_data_i, r_asm};
              r_pc    <= r_base;
              r_valid <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.rdy_o        = (r_state == IF_MEM_IDLE);
  assign bus.mem_rd_o     = w_issue;
  assign bus.mem_addr_o   = w_issue ? w_mem_addr : '0;
  assign bus.inst_valid_o = r_valid;
  assign bus.inst_o       = r_inst;
  assign bus.inst_pc_o    = r_pc;

endmodule

// File: tb/tb_if_mem_ctrl.sv
// tb_if_mem_ctrl: directed fetch scenarios with a byte-memory model.
// Expected reads and instructions are queued by the driver, checked by monitors.
module tb_if_mem_ctrl;
  import if_mem_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int MAW = 17;

  typedef struct {
    logic [31:0]   inst;
    logic [AW-1:0] pc;
    int            c;
  } exp_inst_t;

  typedef struct {
    logic [MAW-1:0] a;
    int             c;
  } exp_rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_inst_t q_inst[$];
  exp_rd_t   q_rd[$];
  logic [7:0] mem [0:(1<<MAW)-1];

  if_mem_ctrl_if #(.ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) bus ();

  if_mem_ctrl #(.ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_rd_o) bus.mem_data_i <= mem[bus.mem_addr_o];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin : mon
    exp_rd_t   er;
    exp_inst_t ei;
    if (bus.mem_rd_o) begin
      if (q_rd.size() == 0) begin
        chk("unexpected mem_rd_o", 64'(bus.mem_addr_o), 64'hFFFF_FFFF);
      end else begin
        er = q_rd.pop_front();
        chk("mem_addr_o", 64'(bus.mem_addr_o), 64'(er.a));
        chk("mem_rd_o cycle", 64'(cyc), 64'(er.c));
      end
    end
    if (bus.inst_valid_o) begin
      if (q_inst.size() == 0) begin
        chk("unexpected inst_valid_o", 64'(bus.inst_o), 64'hFFFF_FFFF_FFFF);
      end else begin
        ei = q_inst.pop_front();
        chk("inst_o", 64'(bus.inst_o), 64'(ei.inst));
        chk("inst_pc_o", 64'(bus.inst_pc_o), 64'(ei.pc));
        chk("inst_valid_o cycle", 64'(cyc), 64'(ei.c));
      end
    end
  end

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_reads(input logic [MAW-1:0] base,
                            input int c0, input int n);
    for (int k = 0; k < n; k++)
      q_rd.push_back('{a: MAW'(base + MAW'(k)), c: c0 + 1 + k});
  endtask

  task automatic push_inst(input logic [31:0] inst,
                           input logic [AW-1:0] pc, input int c);
    q_inst.push_back('{inst: inst, pc: pc, c: c});
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " rdy_o"}, 64'(bus.rdy_o), 64'd1);
    chk({tag, " inst_valid_o"}, 64'(bus.inst_valid_o), 64'd0);
    chk({tag, " inst_o"}, 64'(bus.inst_o), 64'd0);
    chk({tag, " inst_pc_o"}, 64'(bus.inst_pc_o), 64'd0);
    chk({tag, " mem_rd_o"}, 64'(bus.mem_rd_o), 64'd0);
    chk({tag, " mem_addr_o"}, 64'(bus.mem_addr_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < (1 << MAW); i++) mem[i] = 8'h00;
    mem[17'h00100] = 8'h13; mem[17'h00101] = 8'h05;
    mem[17'h00102] = 8'h10; mem[17'h00103] = 8'h00;
    mem[17'h00104] = 8'h93; mem[17'h00105] = 8'h05;
    mem[17'h00106] = 8'h20; mem[17'h00107] = 8'h00;
    mem[17'h00200] = 8'h6F; mem[17'h00201] = 8'h00;
    mem[17'h00202] = 8'h00; mem[17'h00203] = 8'h00;
    mem[17'h1FFFE] = 8'h37; mem[17'h1FFFF] = 8'h01;
    mem[17'h00000] = 8'h02; mem[17'h00001] = 8'h03;

    bus.req_i      = 1'b0;
    bus.addr_i     = '0;
    bus.flush_i    = 1'b0;
    bus.mem_data_i = '0;
    rst            = 1'b1;

    // Reset for two cycles, then idle
    go(2);
    chk_idle_zero("reset");
    rst = 1'b0;
    go(5);
    chk("idle rdy_o", 64'(bus.rdy_o), 64'd1);

    // Single fetch, then back-to-back in cycle 6
    c = cyc;
    bus.req_i = 1'b1; bus.addr_i = 32'h100;
    push_reads(17'h100, c, 4);
    push_inst(32'h0010_0513, 32'h100, c + 6);
    go(c + 1);
    bus.req_i = 1'b0;
    go(c + 3);
    chk("busy rdy_o", 64'(bus.rdy_o), 64'd0);
    go(c + 6);
    chk("valid-cycle rdy_o", 64'(bus.rdy_o), 64'd1);
    bus.req_i = 1'b1; bus.addr_i = 32'h104;
    push_reads(17'h104, c + 6, 4);
    push_inst(32'h0020_0593, 32'h104, c + 12);
    go(c + 7);
    bus.req_i = 1'b0;
    for (int k = 7; k <= 11; k++) begin
      go(c + k);
      chk("b2b rdy_o", 64'(bus.rdy_o), 64'd0);
    end
    go(c + 12);
    chk("b2b done rdy_o", 64'(bus.rdy_o), 64'd1);

    // Flush with redirect in cycle 3
    c = cyc + 2;
    go(c);
    bus.req_i = 1'b1; bus.addr_i = 32'h100;
    push_reads(17'h100, c, 3);
    go(c + 1);
    bus.req_i = 1'b0;
    go(c + 3);
    bus.flush_i = 1'b1; bus.req_i = 1'b1; bus.addr_i = 32'h200;
    push_reads(17'h200, c + 3, 4);
    push_inst(32'h0000_006F, 32'h200, c + 9);
    go(c + 4);
    bus.flush_i = 1'b0; bus.req_i = 1'b0;
    go(c + 4);
    chk("redirect rdy_o", 64'(bus.rdy_o), 64'd0);
    go(c + 10);

    // Flush in the cycle the last byte lands
    c = cyc;
    bus.req_i = 1'b1; bus.addr_i = 32'h104;
    push_reads(17'h104, c, 4);
    go(c + 1);
    bus.req_i = 1'b0;
    go(c + 5);
    bus.flush_i = 1'b1;
    go(c + 6);
    bus.flush_i = 1'b0;
    chk("lastflush rdy_o", 64'(bus.rdy_o), 64'd1);
    chk("lastflush inst_valid_o", 64'(bus.inst_valid_o), 64'd0);
    chk("lastflush inst_o held", 64'(bus.inst_o), 64'h6F);
    chk("lastflush inst_pc_o held", 64'(bus.inst_pc_o), 64'h200);
    go(c + 8);

    // Wrap at top of memory; flush in IDLE is harmless;
    // a request while busy is ignored
    c = cyc;
    bus.flush_i = 1'b1; bus.req_i = 1'b1; bus.addr_i = 32'h1FFFE;
    push_reads(17'h1FFFE, c, 4);
    push_inst(32'h0302_0137, 32'h1FFFE, c + 6);
    go(c + 1);
    bus.flush_i = 1'b0; bus.req_i = 1'b0;
    go(c + 2);
    bus.req_i = 1'b1; bus.addr_i = 32'h300;
    go(c + 4);
    bus.req_i = 1'b0;
    go(c + 8);
    chk("wrap inst_o", 64'(bus.inst_o), 64'h0302_0137);

    // Reset in cycle 3 of a fetch
    c = cyc;
    bus.req_i = 1'b1; bus.addr_i = 32'h100;
    push_reads(17'h100, c, 3);
    go(c + 1);
    bus.req_i = 1'b0;
    go(c + 3);
    rst = 1'b1;
    go(c + 4);
    chk_idle_zero("midreset");
    rst = 1'b0;
    go(c + 14);
    chk("midreset inst_o", 64'(bus.inst_o), 64'd0);

    chk("leftover reads", 64'(q_rd.size()), 64'd0);
    chk("leftover insts", 64'(q_inst.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
